supply_ledger: RTL

Per-player ammo and health bookkeeping for the two-player game; the consuming end of the red-box pickup interface. Counts rising edges on the box `Replenish` lines, credits each pickup to the player named by `Replenish_Player`, grants fire requests against the ammo count with a frame-based cooldown, and applies damage hits. Sits between the box/devil logic and the player/bullet/HUD logic; all outputs are registered.

---
 rtl/supply_pkg.sv | 29 ++
 rtl/supply_player.sv | 98 +++++++++
 rtl/supply_ledger.sv | 125 ++++++++++++
 3 files changed

// File: rtl/supply_pkg.sv
// Shared types, parameter defaults and saturation helper for the supply ledger.
package supply_pkg;

  typedef enum logic [1:0] {
    READY,
    COOLDOWN,
    DEAD
  } player_state_e;

  localparam int unsigned AMMO_INIT_DEF     = 30;
  localparam int unsigned AMMO_MAX_DEF      = 99;
  localparam int unsigned AMMO_PER_BOX_DEF  = 10;
  localparam int unsigned HP_MAX_DEF        = 100;
  localparam int unsigned HP_PER_BOX_DEF    = 20;
  localparam int unsigned DMG_DEF           = 10;
  localparam int unsigned FIRE_COOLDOWN_DEF = 8;

  // Saturate a signed intermediate into [0, hi].
  function automatic logic [6:0] clamp(input logic signed [10:0] v, input logic [6:0] hi);
    if (v < 11'sd0) begin
      return '0;
    end else if (v > $signed({4'b0000, hi})) begin
      return hi;
    end else begin
      return v[6:0];
    end
  endfunction

endpackage

// File: rtl/supply_player.sv
// One player's fire/cooldown/death FSM with its ammo and health registers.
module supply_player
  import supply_pkg::*;
#(
  parameter int unsigned AMMO_INIT     = AMMO_INIT_DEF,
  parameter int unsigned AMMO_MAX      = AMMO_MAX_DEF,
  parameter int unsigned AMMO_PER_BOX  = AMMO_PER_BOX_DEF,
  parameter int unsigned HP_MAX        = HP_MAX_DEF,
  parameter int unsigned HP_PER_BOX    = HP_PER_BOX_DEF,
  parameter int unsigned DMG           = DMG_DEF,
  parameter int unsigned FIRE_COOLDOWN = FIRE_COOLDOWN_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       fire_req,
  input  logic       hit,
  input  logic       heal,
  input  logic [3:0] add_n,
  output logic       fire_ack,
  output logic [6:0] ammo,
  output logic [6:0] hp,
  output logic       dead
);

  localparam logic [10:0] AMMO_STEP = 11'(AMMO_PER_BOX);
  localparam logic [10:0] HP_STEP   = 11'(HP_PER_BOX);
  localparam logic [10:0] DMG_STEP  = 11'(DMG);
  localparam logic [6:0]  AMMO_TOP  = 7'(AMMO_MAX);
  localparam logic [6:0]  HP_TOP    = 7'(HP_MAX);

  player_state_e state, state_next;
  logic [7:0] cd, cd_next;
  logic [6:0] ammo_next, hp_next;
  logic       ack_next;
  logic       grant;
  logic signed [10:0] ammo_sum, ammo_keep, hp_sum;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= READY;
      cd       <= '0;
      ammo     <= 7'(AMMO_INIT);
      hp       <= HP_TOP;
      fire_ack <= 1'b0;
      dead     <= 1'b0;
    end else begin
      state    <= state_next;
      cd       <= cd_next;
      ammo     <= ammo_next;
      hp       <= hp_next;
      fire_ack <= ack_next;
      dead     <= (state_next == DEAD);
    end
  end

  always_comb begin
    state_next = state;
    cd_next    = cd;
    ammo_next  = ammo;
    hp_next    = hp;
    ack_next   = 1'b0;

    // Grant is judged on the current ammo, before any same-cycle pickup.
    grant     = (state == READY) && fire_req && (ammo != '0);
    ammo_sum  = 11'(ammo) - 11'(grant) + 11'(add_n) * AMMO_STEP;
    ammo_keep = 11'(ammo) + 11'(add_n) * AMMO_STEP;
    hp_sum    = 11'(hp) - (hit ? DMG_STEP : 11'd0) + 11'(add_n) * HP_STEP + 11'(heal);

    if (state != DEAD) begin
      if (hp_sum <= 11'sd0) begin
        // Death wins over a same-cycle grant: no ack and no round spent.
        state_next = DEAD;
        cd_next    = '0;
        hp_next    = '0;
        ammo_next  = clamp(ammo_keep, AMMO_TOP);
      end else begin
        hp_next   = clamp(hp_sum, HP_TOP);
        ammo_next = clamp(ammo_sum, AMMO_TOP);
        if (state == READY) begin
          if (grant) begin
            ack_next   = 1'b1;
            cd_next    = 8'(FIRE_COOLDOWN);
            state_next = COOLDOWN;
          end
        end else if (tick) begin
          if (cd <= 8'd1) begin
            cd_next    = '0;
            state_next = READY;
          end else begin
            cd_next = cd - 8'd1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/supply_ledger.sv
// Two-player ammo/health ledger fed by red-box pickups, fire requests and hits.
// Optional SUPPLY_AUTOHEAL_EN adds +1 HP every 64 frame ticks to living players.
module supply_ledger
  import supply_pkg::*;
#(
  parameter int unsigned AMMO_INIT     = AMMO_INIT_DEF,
  parameter int unsigned AMMO_MAX      = AMMO_MAX_DEF,
  parameter int unsigned AMMO_PER_BOX  = AMMO_PER_BOX_DEF,
  parameter int unsigned HP_MAX        = HP_MAX_DEF,
  parameter int unsigned HP_PER_BOX    = HP_PER_BOX_DEF,
  parameter int unsigned DMG           = DMG_DEF,
  parameter int unsigned FIRE_COOLDOWN = FIRE_COOLDOWN_DEF
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            frame_clk,
  input  logic [9:0]      Replenish,
  input  logic [9:0]      Replenish_Player,
  input  logic [1:0]      Fire_Req,
  input  logic [1:0]      Hit,
  output logic [1:0]      Fire_Ack,
  output logic [1:0][6:0] Ammo,
  output logic [1:0][6:0] HP,
  output logic [1:0]      Dead
);

  logic            frame_prev;
  logic [9:0]      rep_prev;
  logic [1:0]      hit_prev;
  logic [9:0]      rise;
  logic [1:0][3:0] add_n, add_q;
  logic            tick_q;
  logic [1:0]      hit_q, fire_q;
  logic            heal;

  assign rise = Replenish & ~rep_prev;

  always_comb begin
    add_n = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (rise[i]) begin
        add_n[Replenish_Player[i]] = add_n[Replenish_Player[i]] + 4'd1;
      end
    end
  end

  // Fire_Req is staged with the edge pulses so all inputs share the same latency.
  always_ff @(posedge Clk) begin
    frame_prev <= frame_clk;
    rep_prev   <= Replenish;
    hit_prev   <= Hit;
    if (Reset) begin
      tick_q <= 1'b0;
      hit_q  <= '0;
      fire_q <= '0;
      add_q  <= '0;
    end else begin
      tick_q <= frame_clk & ~frame_prev;
      hit_q  <= Hit & ~hit_prev;
      fire_q <= Fire_Req;
      add_q  <= add_n;
    end
  end

`ifdef SUPPLY_AUTOHEAL_EN
  logic [5:0] heal_cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      heal_cnt <= '0;
    end else if (tick_q) begin
      heal_cnt <= heal_cnt + 6'd1;
    end
  end

  assign heal = tick_q && (heal_cnt == '1);
`else
  assign heal = 1'b0;
`endif

  supply_player #(
    .AMMO_INIT    (AMMO_INIT),
    .AMMO_MAX     (AMMO_MAX),
    .AMMO_PER_BOX (AMMO_PER_BOX),
    .HP_MAX       (HP_MAX),
    .HP_PER_BOX   (HP_PER_BOX),
    .DMG          (DMG),
    .FIRE_COOLDOWN(FIRE_COOLDOWN)
  ) u_player0 (
    .clk     (Clk),
    .reset   (Reset),
    .tick    (tick_q),
    .fire_req(fire_q[0]),
    .hit     (hit_q[0]),
    .heal    (heal),
    .add_n   (add_q[0]),
    .fire_ack(Fire_Ack[0]),
    .ammo    (Ammo[0]),
    .hp      (HP[0]),
    .dead    (Dead[0])
  );

  supply_player #(
    .AMMO_INIT    (AMMO_INIT),
    .AMMO_MAX     (AMMO_MAX),
    .AMMO_PER_BOX (AMMO_PER_BOX),
    .HP_MAX       (HP_MAX),
    .HP_PER_BOX   (HP_PER_BOX),
    .DMG          (DMG),
    .FIRE_COOLDOWN(FIRE_COOLDOWN)
  ) u_player1 (
    .clk     (Clk),
    .reset   (Reset),
    .tick    (tick_q),
    .fire_req(fire_q[1]),
    .hit     (hit_q[1]),
    .heal    (heal),
    .add_n   (add_q[1]),
    .fire_ack(Fire_Ack[1]),
    .ammo    (Ammo[1]),
    .hp      (HP[1]),
    .dead    (Dead[1])
  );

endmodule
